// File: rtl/booth_mul_ctrl.sv
// Radix-2 Booth sequencer for signed 32x32 multiply that time-shares the
// datapath's 32-bit adder; a 33rd accumulator bit (E) carries the true sign.
module booth_mul_ctrl #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] multiplicand_i,
    input  logic [DATA_WIDTH-1:0] multiplier_i,
    output logic [DATA_WIDTH-1:0] add_a_o,
    output logic [DATA_WIDTH-1:0] add_b_o,
    input  logic [DATA_WIDTH-1:0] add_z_i,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_NEG, S_ITER, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   m_q, m_d;
    logic [W-1:0]   neg_m_q, neg_m_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           e_q, e_d;
    logic           q1_q, q1_d;
    logic [CW-1:0]  count_q, count_d;
    logic [W-1:0]   add_a_q, add_a_d;
    logic [W-1:0]   add_b_q, add_b_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [1:0]     sel;
    logic [W-1:0]   addend;
    logic           b_e;
    logic           c31;
    logic           cout;
    logic           new_e;

    function automatic logic [W-1:0] pick_addend(input logic [1:0]   s,
                                                 input logic [W-1:0] m,
                                                 input logic [W-1:0] neg_m);
        case (s)
            2'b01:   return m;
            2'b10:   return neg_m;
            default: return '0;
        endcase
    endfunction

    // One Booth step: 33-bit add of {E,HI} and the sign-extended addend
    always_comb begin
        sel    = {lo_q[0], q1_q};
        addend = pick_addend(sel, m_q, neg_m_q);
        case (sel)
            2'b01:   b_e = m_q[W-1];
            2'b10:   b_e = (m_q != '0) & ~m_q[W-1];
            default: b_e = 1'b0;
        endcase
        c31   = add_z_i[W-1] ^ hi_q[W-1] ^ addend[W-1];
        cout  = (hi_q[W-1] & addend[W-1]) | (hi_q[W-1] & c31) | (addend[W-1] & c31);
        new_e = e_q ^ b_e ^ cout;
    end

    // Adder operands are registered, so they are computed from next-state values
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        neg_m_d = neg_m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        e_d     = e_q;
        q1_d    = q1_q;
        count_d = count_q;
        add_a_d = '0;
        add_b_d = '0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    m_d     = multiplicand_i;
                    hi_d    = '0;
                    e_d     = 1'b0;
                    lo_d    = multiplier_i;
                    q1_d    = 1'b0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    add_a_d = ~multiplicand_i;
                    add_b_d = W'(1);
                    state_d = S_NEG;
                end
            end
            S_NEG: begin
                neg_m_d = add_z_i;
                add_a_d = hi_q;
                add_b_d = pick_addend({lo_q[0], q1_q}, m_q, add_z_i);
                state_d = S_ITER;
            end
            S_ITER: begin
                e_d     = new_e;
                hi_d    = {new_e, add_z_i[W-1:1]};
                lo_d    = {add_z_i[0], lo_q[W-1:1]};
                q1_d    = lo_q[0];
                count_d = count_q + CW'(1);
                if (count_q == CW'(W - 1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    add_a_d = {new_e, add_z_i[W-1:1]};
                    add_b_d = pick_addend({lo_q[1], lo_q[0]}, m_q, neg_m_q);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            neg_m_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            e_q     <= 1'b0;
            q1_q    <= 1'b0;
            count_q <= '0;
            add_a_q <= '0;
            add_b_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            neg_m_q <= neg_m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            e_q     <= e_d;
            q1_q    <= q1_d;
            count_q <= count_d;
            add_a_q <= add_a_d;
            add_b_q <= add_b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign add_a_o = add_a_q;
    assign add_b_o = add_b_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Directed bench for booth_mul_ctrl: product table, handshake timing, held
// start, mid-run clear, and a per-cycle check of the shared adder operands.
module tb_booth_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] mcand, mplier;
    logic [31:0] add_a, add_b, add_z;
    logic [31:0] hi, lo;
    logic        busy, done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Shared adder: plain 32-bit sum, no carry-in
    assign add_z = add_a + add_b;

    booth_mul_ctrl #(.DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .multiplicand_i (mcand),
        .multiplier_i   (mplier),
        .add_a_o        (add_a),
        .add_b_o        (add_b),
        .add_z_i        (add_z),
        .hi_o           (hi),
        .lo_o           (lo),
        .busy_o         (busy),
        .done_o         (done)
    );

    typedef struct {
        logic [31:0] m;
        logic [31:0] q;
        logic [63:0] p;
    } vec_t;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Adder operand expectation for one ITER cycle
    function automatic logic [31:0] exp_addend(input logic lo0, input logic q1,
                                               input logic [31:0] m, input logic [31:0] negm);
        case ({lo0, q1})
            2'b01:   return m;
            2'b10:   return negm;
            default: return 32'd0;
        endcase
    endfunction

    // Full operation: lat is edges from accept to the edge closing the done cycle
    task automatic run_op(input logic [31:0] m, input logic [31:0] q,
                          output logic [63:0] prod, output int lat,
                          output int busy_cyc, output int mon_bad, output int idle_bad);
        logic [31:0] negm;
        logic        q1;
        negm     = ~m + 32'd1;
        q1       = 1'b0;
        lat      = -1;
        busy_cyc = 0;
        mon_bad  = 0;
        idle_bad = 0;
        @(negedge clk);
        mcand  = m;
        mplier = q;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (busy) busy_cyc++;
        if (add_a !== ~m || add_b !== 32'd1) mon_bad++;
        for (int n = 1; n <= 60 && lat < 0; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n + 1;
            end else begin
                if (busy) busy_cyc++;
                if (add_a !== hi || add_b !== exp_addend(lo[0], q1, m, negm)) mon_bad++;
                q1 = lo[0];
            end
        end
        prod = {hi, lo};
        if (busy || add_a !== 32'd0 || add_b !== 32'd0) idle_bad++;
        @(posedge clk); #1;
        if (done || busy || add_a !== 32'd0 || add_b !== 32'd0 || {hi, lo} !== prod) idle_bad++;
    endtask

    vec_t        vecs[10];
    logic [63:0] prod, prod1;
    int          lat, bcyc, mbad, ibad, seen_done, waited;

    initial begin
        vecs[0] = '{32'd7,        32'd22,       64'h00000000_0000009A};
        vecs[1] = '{32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1};
        vecs[2] = '{32'd100,      32'hFFFFFF6A, 64'hFFFFFFFF_FFFFC568};
        vecs[3] = '{32'h80000000, 32'h80000000, 64'h40000000_00000000};
        vecs[4] = '{32'h80000000, 32'd1,        64'hFFFFFFFF_80000000};
        vecs[5] = '{32'hFFFFFFFF, 32'd1,        64'hFFFFFFFF_FFFFFFFF};
        vecs[6] = '{32'd0,        32'h7FFFFFFF, 64'h00000000_00000000};
        vecs[7] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001};
        vecs[8] = '{32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000};
        vecs[9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};

        rst_n  = 1'b0;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        #12;
        check64("reset_state", {hi, lo, add_a, add_b, 30'd0, busy, done} >> 0 == '0 ? 64'd0 : 64'd1, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].m, vecs[i].q, prod, lat, bcyc, mbad, ibad);
            check64($sformatf("product[%0d]", i), prod, vecs[i].p);
            check_int($sformatf("latency[%0d]", i), lat, 34);
            check_int($sformatf("busy_cycles[%0d]", i), bcyc, 33);
            check_int($sformatf("adder_monitor[%0d]", i), mbad, 0);
            check_int($sformatf("idle_after_done[%0d]", i), ibad, 0);
        end

        // start held high; operands change mid-run
        @(negedge clk);
        mcand  = 32'd7;
        mplier = 32'd22;
        start  = 1'b1;
        @(posedge clk); #1;
        seen_done = 0;
        waited    = 0;
        while (!done && waited < 60) begin
            @(posedge clk); #1;
            waited++;
            if (waited == 3) begin
                mcand  = 32'hFFFFFFFD;
                mplier = 32'd5;
            end
        end
        check_int("held_first_latency", waited + 1, 34);
        prod1 = {hi, lo};
        check64("held_first_product", prod1, 64'h00000000_0000009A);
        @(posedge clk); #1;
        check64("held_idle_gap", {31'd0, busy, hi, lo}, {32'd0, 64'h00000000_0000009A});
        @(posedge clk); #1;
        check_int("held_second_accept", int'(busy), 1);
        waited = 0;
        while (!done && waited < 60) begin
            @(posedge clk); #1;
            waited++;
        end
        start = 1'b0;
        check_int("held_second_latency", waited + 1, 34);
        check64("held_second_product", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        @(posedge clk); #1;

        // clear in the middle of ITER
        @(negedge clk);
        mcand  = 32'd100;
        mplier = 32'hFFFFFF6A;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check64("clear_hi_lo", {hi, lo}, 64'd0);
        check64("clear_ctrl", {add_a, add_b}, 64'd0);
        check_int("clear_busy_done", int'({busy, done}), 0);
        seen_done = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done++;
        end
        check_int("clear_no_done", seen_done, 0);
        run_op(32'd100, 32'hFFFFFF6A, prod, lat, bcyc, mbad, ibad);
        check64("post_clear_product", prod, 64'hFFFFFFFF_FFFFC568);
        check_int("post_clear_latency", lat, 34);
        check_int("post_clear_monitor", mbad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_mul_ctrl.md
# booth_mul_ctrl

Multi-cycle signed 32x32 multiplier sequencer that time-shares the datapath's single 32-bit carry-lookahead adder (`cla`, ports Z, A, B, no carry-in) to run radix-2 Booth multiplication. It drives the adder operands, reads the combinational sum back, and produces the 64-bit product on HI/LO for the ALU MUL instruction. It sits between the control unit (start/done handshake) and the shared adder.

## Interface

- DATA_WIDTH, 32, operand width. Only 32 is supported.
- clock  in  1  system clock; all state changes on the rising edge
- clear  in  1  asynchronous, active-low reset
- start  in  1  request; sampled in IDLE only
- multiplicand  in  32  M, signed; captured on the accepting edge
- multiplier  in  32  Q, signed; captured on the accepting edge
- add_a  out  32  shared adder operand A
- add_b  out  32  shared adder operand B
- add_z  in  32  shared adder sum Z (combinational from add_a/add_b)
- hi  out  32  product bits 63:32
- lo  out  32  product bits 31:0
- busy  out  1  high in NEG and ITER
- done  out  1  one-cycle pulse in DONE

## Operation

- States: IDLE, NEG, ITER, DONE.
- IDLE: start=1 captures M, Q; loads HI=0, E=0 (33rd accumulator bit), LO=Q, q_1=0, count=0; goes to NEG. start=0: stay.
- NEG: add_a=~M, add_b=1; registers negM=add_z (two's complement of M); goes to ITER.
- ITER (one cycle per iteration, 32 iterations):
  - Select on {LO[0], q_1}: 01 -> addend=M, sign bE=M[31]; 10 -> addend=negM, bE=~M[31] when M!=0, else 0; 00/11 -> addend=0, bE=0.
  - add_a=HI, add_b=addend; S=add_z.
  - 33-bit sign: c31=S[31]^HI[31]^addend[31]; cout=majority(HI[31], addend[31], c31); newE=E^bE^cout.
  - Arithmetic shift right of {newE, S, LO, q_1} by one, newE replicated into E. Result is the new E, HI, LO, q_1.
  - count increments; after count=31 goes to DONE.
- DONE: done=1 for one cycle, then IDLE. hi/lo remain valid and held until the next accepted start.
- hi = HI register, lo = LO register at all times (intermediate values are visible while busy; consumers use them only after done).
- In IDLE and DONE: add_a=0, add_b=0.
- start while busy or in DONE is ignored, not queued.
- M = 0x80000000 handled by the E bit: negM register = 0x80000000 with bE=0 (true +2^31).

## Timing

- clear=0 (any time, including mid-operation): state=IDLE, HI=LO=0, E=0, q_1=0, count=0, negM=0, busy=0, done=0, add_a=add_b=0. Operation is aborted with no completion pulse.
- Start accepted at edge k: busy=1 from k through k+33. NEG at cycle k..k+1. ITER edges k+2..k+33. DONE entered at edge k+33, so done=1 for the cycle ending at edge k+34, and busy=0 in that cycle.
- Latency: 34 clocks from the accepting edge to done high. The next start is accepted at edge k+35 at the earliest (IDLE).
- The adder path is combinational. add_a/add_b to add_z to register must close within one clock.

## Test plan

- M=7, Q=22: start one cycle -> done exactly 34 edges later; {hi,lo}=0x00000000_0000009A; busy high 33 cycles.
- M=-3 (0xFFFFFFFD), Q=5 -> {hi,lo}=0xFFFFFFFF_FFFFFFF1; M=100, Q=-150 -> 0xFFFFFFFF_FFFFC568.
- Corners: M=Q=0x80000000 -> 0x40000000_00000000; M=0x80000000, Q=1 -> 0xFFFFFFFF_80000000; M=0xFFFFFFFF, Q=1 -> 0xFFFFFFFF_FFFFFFFF; M=0, Q=0x7FFFFFFF -> 0.
- start held high continuously, with operands changed mid-run -> the first product is unaffected; the second operation is accepted only in IDLE after done; back-to-back results are both correct.
- clear=0 asserted at ITER iteration 10 -> all outputs are 0 immediately (asynchronously); no done pulse. A new start after release gives the correct product.
- Adder monitor: in NEG, add_a=~M and add_b=1. In each ITER cycle, add_b is in {M, negM, 0}, matching {LO[0], q_1}.
